// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the execute stage and the mul/div unit.
interface mul_div_unit_if #(
    parameter int word_size = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [word_size-1:0] operand_a;
    logic [word_size-1:0] operand_b;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic [word_size-1:0] result;

    modport master (output start, op, operand_a, operand_b, flush, input busy, done, result);
    modport slave  (input start, op, operand_a, operand_b, flush, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: one-bit-per-cycle unsigned shift-add multiplier and restoring divider.
module mul_div_unit #(
    parameter int word_size  = 32,
    parameter int count_size = 5
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]             state, op_q;
    logic [count_size-1:0]  cnt;
    logic [word_size-1:0]   mcand, divisor, rem, rem_n, quot, quot_n, fin, res_q;
    logic [2*word_size-1:0] acc, acc_n;
    logic [word_size:0]     sum, shifted, diff;
    logic                   accept, div0;

    assign accept     = bus.start && state != RUN;
    assign div0       = bus.op[1] && bus.operand_b == '0;
    assign bus.busy   = state == RUN;
    assign bus.done   = state == DONE;
    assign bus.result = res_q;

    always_comb begin
        sum     = {1'b0, acc[2*word_size-1:word_size]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_n   = {sum, acc[word_size-1:1]};
        shifted = {rem, quot[word_size-1]};
        diff    = shifted - {1'b0, divisor};
        // a set top bit means the trial subtraction went negative, so restore
        rem_n   = diff[word_size] ? shifted[word_size-1:0] : diff[word_size-1:0];
        quot_n  = {quot[word_size-2:0], ~diff[word_size]};
        fin     = op_q == 2'b00 ? acc_n[word_size-1:0] :
                  op_q == 2'b01 ? acc_n[2*word_size-1:word_size] :
                  op_q == 2'b10 ? quot_n : rem_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            mcand   <= '0;
            divisor <= '0;
            acc     <= '0;
            rem     <= '0;
            quot    <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else if (accept) begin
            op_q    <= bus.op;
            mcand   <= bus.operand_a;
            divisor <= bus.operand_b;
            acc     <= {{word_size{1'b0}}, bus.operand_b};
            rem     <= '0;
            quot    <= bus.operand_a;
            cnt     <= '0;
            state   <= div0 ? DONE : RUN;
            if (div0)
                res_q <= bus.op[0] ? bus.operand_a : '1;
        end else if (state == RUN) begin
            acc  <= acc_n;
            rem  <= rem_n;
            quot <= quot_n;
            cnt  <= cnt + 1'b1;
            // the result is captured from the final iteration so it is valid in DONE
            if (cnt == count_size'(word_size - 1)) begin
                state <= DONE;
                res_q <= fin;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: vector table plus corner sequences, results checked through a scoreboard queue.
module tb_mul_div_unit;
    localparam logic [1:0] MUL = 2'b00, MULHU = 2'b01, DIVU = 2'b10, REMU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if #(.word_size(32)) bus();
    mul_div_unit #(.word_size(32), .count_size(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    vec_t        vecs[13];
    logic [31:0] sb[$];
    logic [31:0] last_exp = '0;
    int          checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            MUL:     return p[31:0];
            MULHU:   return p[63:32];
            DIVU:    return b == 0 ? 32'hFFFF_FFFF : a / b;
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst && (bus.busy || bus.done))
            chk("busy_done_exclusive", 32'(bus.busy && bus.done), 32'd0);
        if (rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %h with no request outstanding", bus.result);
            end else begin
                last_exp = sb.pop_front();
                chk("result", bus.result, last_exp);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        sb.push_back(exp);
    endtask

    task automatic wait_done(output int bn, output bit found);
        bn    = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.done) found = 1'b1;
            else begin
                if (bus.busy) bn++;
                @(negedge clk);
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles");
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int t0, bn;
        bit found;
        @(negedge clk);
        issue(op, a, b, exp);
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
        wait_done(bn, found);
        if (found) begin
            chk("latency", 32'(cyc - t0), 32'(lat));
            chk("busy_cycles", 32'(bn), 32'(lat));
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d1, bn;
        bit found;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        vecs[0]  = '{MUL,   32'd7,          32'd6,          32'd42,         32};
        vecs[1]  = '{MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32};
        vecs[2]  = '{MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32};
        vecs[3]  = '{DIVU,  32'd100,        32'd7,          32'd14,         32};
        vecs[4]  = '{REMU,  32'd100,        32'd7,          32'd2,          32};
        vecs[5]  = '{DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF,  0};
        vecs[6]  = '{REMU,  32'd5,          32'd0,          32'd5,          0};
        vecs[7]  = '{MUL,   32'd0,          32'd12345,      32'd0,          32};
        vecs[8]  = '{MULHU, 32'h8000_0000,  32'd4,          32'd2,          32};
        vecs[9]  = '{DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32};
        vecs[10] = '{REMU,  32'd10,         32'd20,         32'd10,         32};
        vecs[11] = '{DIVU,  32'd10,         32'd20,         32'd0,          32};
        vecs[12] = '{MULHU, 32'h0001_0000,  32'h0001_0000,  32'd1,          32};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = rop[1] ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb), 32);
        end

        // back-to-back DIVU then REMU, second start in the DONE cycle
        @(negedge clk);
        issue(DIVU, 32'd100, 32'd7, 32'd14);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bn, found);
        d1 = cyc;
        issue(REMU, 32'd100, 32'd7, 32'd2);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(bn, found);
        chk("b2b_spacing", 32'(cyc - d1), 32'd33);
        @(negedge clk);

        // back-to-back divide by zero keeps done high for two cycles
        @(negedge clk);
        issue(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("dz_done1", 32'(bus.done), 32'd1);
        chk("dz_busy1", 32'(bus.busy), 32'd0);
        issue(REMU, 32'd9, 32'd0, 32'd9);
        @(negedge clk);
        bus.start = 1'b0;
        chk("dz_done2", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("dz_done_fall", 32'(bus.done), 32'd0);

        // start during RUN is ignored
        @(negedge clk);
        issue(MUL, 32'd7, 32'd6, 32'd42);
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op = DIVU;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bn, found);
        chk("ignored_start_latency", 32'(cyc - t0), 32'd32);
        @(negedge clk);

        // flush mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = MULHU;
        bus.operand_a = 32'hFFFF_FFFF;
        bus.operand_b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_done", 32'(bus.done), 32'd0);
        chk("flush_result", bus.result, last_exp);
        bn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) bn++;
        end
        chk("flush_stays_idle", 32'(bn), 32'd0);

        // reset mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = MUL;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        bn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) bn++;
        end
        chk("midrst_stays_idle", 32'(bn), 32'd0);

        run_op(MUL, 32'd3, 32'd4, 32'd12, 32);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative unsigned multiply/divide unit for the execute stage. Consumes the two source operands read from the register bank (ReadData1 and ReadData2). Produces a word-size result that is written back to the register bank. Computes one bit per clock. It stalls the pipeline through `busy` and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `word_size`, 32, operand and result width.
- `count_size`, 5, iteration counter width; equals log2(word_size).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-low: sampled on the rising edge of `clk`; `rst == 0` resets.
- `start`  in  1  request; sampled only when the unit is idle or in DONE.
- `op`  in  2  operation code: 00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- `operand_a`  in  word_size  multiplicand or dividend; driven from ReadData1.
- `operand_b`  in  word_size  multiplier or divisor; driven from ReadData2.
- `flush`  in  1  synchronous abort of any operation in flight.
- `busy`  out  1  high while an operation is iterating; the pipeline holds while this is high.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  word_size  result of the last completed operation; held until the next completion.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: presenting the result for one cycle.
- IDLE + `start`:
  - Latch `op`, `operand_a` and `operand_b`.
  - Clear the counter.
  - If the op is DIVU or REMU and `operand_b == 0`, go to DONE directly. Otherwise go to RUN.
- Multiply (shift-add):
  - Keep a 2*word_size product accumulator.
  - Each RUN cycle: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right by 1 (keeping the carry).
- Divide (restoring):
  - Keep a word_size+1 partial remainder and a quotient register.
  - Each RUN cycle: shift {remainder, quotient} left by 1, then trial-subtract the divisor.
  - If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
- RUN advances the counter by 1 each cycle. When the counter reaches word_size-1, the state goes to DONE.
- DONE:
  - Load `result` from the field selected by `op`: product[31:0], product[63:32], quotient or remainder.
  - Assert `done`.
  - If `start` is high, accept the new request (same rules as IDLE). Otherwise go to IDLE.
- Divide by zero: DIVU returns 0xFFFFFFFF; REMU returns `operand_a`.
- All arithmetic is unsigned, and results wrap to word_size. There is no overflow flag.
- `flush` has priority over `start`:
  - Any state goes to IDLE.
  - `busy` and `done` go to 0.
  - `result` holds its previous value.
- Reset has priority over everything:
  - State goes to IDLE.
  - `busy`, `done`, `result` and the counter all go to 0.
  - Applies mid-operation; no `done` is generated for the aborted operation.
- `start` while in RUN is ignored; the latched operands are not disturbed.

## Timing
- Reset values: `busy = 0`, `done = 0`, `result = 0`.
- `start` sampled at edge E0 (normal op):
  - `busy = 1` from after E0 through E32 (32 RUN cycles).
  - After E32: `busy = 0`, `done = 1`, `result` valid.
  - After E33: `done = 0` unless a new operation completes.
- Latency from start to done is word_size cycles.
- Divide by zero, `start` at E0: after E0, `done = 1` and `busy = 0`. Latency is 1 cycle and `busy` never rises.
- Back-to-back: `start` in the DONE cycle (sampled at E33) gives `busy = 1` after E33, with no idle gap.
- `busy` and `done` are never high in the same cycle.
- `done` never stays high for two consecutive cycles, except for back-to-back divide-by-zero requests.

## Test plan
- After reset: `busy = 0`, `done = 0`, `result = 0`.
- MUL 7 × 6:
  - `start` at E0.
  - `busy` is high for exactly 32 cycles.
  - `done` pulses after E32 with `result = 42`.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL gives `result = 0x00000001`.
  - MULHU gives `result = 0xFFFFFFFE`.
  - Both complete with 32-cycle latency.
- 100 / 7:
  - DIVU gives 14.
  - REMU gives 2.
  - A back-to-back DIVU then REMU with `start` in the DONE cycle gives the second `done` exactly 33 cycles after the first.
- Divide by zero, 5 / 0:
  - DIVU gives 0xFFFFFFFF and REMU gives 5.
  - `done` rises after E0 and `busy` stays 0.
- Abort and ignored requests:
  - `start` pulsed at cycle 10 of RUN with different operands: ignored, and the original result comes out.
  - `flush` at cycle 15: `busy` drops the next cycle, no `done`, `result` unchanged.
  - `rst = 0` at cycle 20: all outputs go to 0.
